seven_seg_scan_ctrl: RTL and testbench

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl_if.sv | 27 ++
 rtl/seven_seg_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-load and scan-output bundle for seven_seg_scan_ctrl.
//   load_valid / load_data / load_ready : valid-ready load of a packed nibble word
//                                         (nibble k = load_data[4k+3:4k], digit 0 rightmost)
//   nibble     : value of the currently selected digit (bit3..bit0 = w,x,y,z)
//   anode_n    : active-low digit enables, at most one low
//   frame_done : one-cycle pulse on the last cycle of each full scan
// master = load source / display consumer, slave = the scan controller.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load_valid;
  logic [4*NUM_DIGITS-1:0]   load_data;
  logic                      load_ready;
  logic [3:0]                nibble;
  logic [NUM_DIGITS-1:0]     anode_n;
  logic                      frame_done;

  modport master (
    output load_valid, load_data,
    input  load_ready, nibble, anode_n, frame_done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, nibble, anode_n, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered display value.
// Each digit is selected for DWELL cycles: BLANK cycles with all anodes off
// (ghosting guard) followed by DRIVE with that digit's anode low. A new value is
// accepted into a shadow register at any time the shadow is empty and is copied
// to the displayed register only at the frame boundary, so a frame never tears.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seven_seg_scan_ctrl_if.slave (load handshake, nibble, anode_n, frame_done)
// Optional feature: define LEADING_ZERO_BLANK_EN to keep leading-zero digits
// (k>0, this and all higher nibbles zero) dark during DRIVE.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int BLANK      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seven_seg_scan_ctrl_if.slave   bus
);

  localparam int CW = $clog2(DWELL);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         active_q, active_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic                  full_q, full_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [3:0]            nib_q, nib_d;
  logic                  fd_q, fd_d;
  logic                  frame_end;
  logic                  dark;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      active_q <= '0;
      shadow_q <= '0;
      full_q   <= 1'b0;
      anode_q  <= '1;
      nib_q    <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      full_q   <= full_d;
      anode_q  <= anode_d;
      nib_q    <= nib_d;
      fd_q     <= fd_d;
    end
  end

  // Outputs are registered from the next-state values so that anode_n, nibble
  // and frame_done line up with the state/index they describe in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    full_d    = full_q;
    anode_d   = '1;
    dark      = 1'b0;
    frame_end = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      state_d = ST_BLANK;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else if (cnt_d == CNT_BLANK) begin
      state_d = ST_DRIVE;
    end

    // Copy and accept are exclusive: copy needs a full shadow, accept an empty one.
    if (frame_end && full_q) begin
      active_d = shadow_q;
      full_d   = 1'b0;
    end else if (bus.load_valid && !full_q) begin
      shadow_d = bus.load_data;
      full_d   = 1'b1;
    end

    fd_d  = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    nib_d = active_d[{idx_d, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    dark = (idx_d != '0) && ((active_d >> {idx_d, 2'b00}) == '0);
`else
    dark = 1'b0;
`endif

    if (state_d == ST_DRIVE && !dark) begin
      anode_d[idx_d] = 1'b0;
    end
  end

  assign bus.load_ready = ~full_q;
  assign bus.nibble     = nib_q;
  assign bus.anode_n    = anode_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DWL   = 10;
  localparam int BL    = 2;
  localparam int FRAME = ND * DWL;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(ND),
    .DWELL     (DWL),
    .BLANK     (BL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cycle position since reset plus the displayed/pending words.
  int unsigned  m_t;
  logic [15:0]  m_active, m_shadow;
  logic         m_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t      <= 0;
      m_active <= '0;
      m_shadow <= '0;
      m_full   <= 1'b0;
    end else begin
      if ((m_t % FRAME) == FRAME - 1 && m_full) begin
        m_active <= m_shadow;
        m_full   <= 1'b0;
      end else if (bus.load_valid && !m_full) begin
        m_shadow <= bus.load_data;
        m_full   <= 1'b1;
      end
      m_t <= m_t + 1;
    end
  end

  function automatic logic [3:0] digit_of(logic [15:0] v, int d);
    logic [15:0] s;
    s = v >> (4 * d);
    return s[3:0];
  endfunction

  function automatic logic [ND-1:0] mdl_anode(int unsigned t, logic [15:0] act);
    logic [ND-1:0] a;
    logic [15:0]   s;
    int            d;
    bit            lit;
    a   = '1;
    d   = int'((t % FRAME) / DWL);
    s   = act >> (4 * d);
    lit = ((t % DWL) >= BL);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && s == 16'h0) lit = 0;
`endif
    if (lit) a[d] = 1'b0;
    return a;
  endfunction

  // Every cycle: never more than one digit enabled.
  always @(negedge clk) begin
    checks++;
    if ($countones(~bus.anode_n) > 1) begin
      errors++;
      $display("FAIL anode_onehot: anode_n=%b, required at most one zero bit", bus.anode_n);
    end
  end

  task automatic wait_fd(output bit ok);
    ok = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.anode_n !== 4'hF) begin errors++; $display("FAIL reset_first_edge_anode: got %b, expected %b", bus.anode_n, 4'hF); end
    @(negedge clk);
    checks++;
    if (bus.anode_n !== 4'hE) begin errors++; $display("FAIL reset_second_edge_anode: got %b, expected %b", bus.anode_n, 4'hE); end
    // load a value, let it reach the display, fill the shadow, then reset mid-DRIVE
    bus.load_valid = 1'b1; bus.load_data = 16'h1234;
    @(negedge clk);
    bus.load_valid = 1'b0;
    wait_fd(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_wait_frame: frame_done not seen, expected within %0d cycles", 3 * FRAME); end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.nibble !== 4'h4) begin errors++; $display("FAIL reset_pre_nibble: got %h, expected %h", bus.nibble, 4'h4); end
    bus.load_valid = 1'b1; bus.load_data = 16'h5678;
    @(negedge clk);
    bus.load_valid = 1'b0;
    checks++;
    if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reset_pre_ready: got %b, expected 0", bus.load_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.anode_n !== 4'hF || bus.nibble !== 4'h0 || bus.load_ready !== 1'b1 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: anode_n=%b nibble=%h load_ready=%b frame_done=%b, expected 1111 0 1 0",
               bus.anode_n, bus.nibble, bus.load_ready, bus.frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.anode_n !== 4'hF) begin errors++; $display("FAIL reset_restart_blank: got %b, expected %b", bus.anode_n, 4'hF); end
    @(negedge clk);
    checks++;
    if (bus.anode_n !== 4'hE || bus.nibble !== 4'h0) begin
      errors++;
      $display("FAIL reset_restart_drive: anode_n=%b nibble=%h, expected 1110 0", bus.anode_n, bus.nibble);
    end
  endtask

  task automatic test_scan();
    bit ok;
    int lows [ND];
    foreach (lows[k]) lows[k] = 0;
    wait_fd(ok);
    repeat (5) @(negedge clk);
    bus.load_valid = 1'b1; bus.load_data = 16'h1234;
    @(negedge clk);
    bus.load_valid = 1'b0;
    wait_fd(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL scan_wait_frame: frame_done not seen, expected within %0d cycles", 3 * FRAME); end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (bus.nibble !== digit_of(16'h1234, i / DWL)) begin
        errors++; $display("FAIL scan_nibble[%0d]: got %h, expected %h", i, bus.nibble, digit_of(16'h1234, i / DWL));
      end
      checks++;
      if (bus.frame_done !== (i == FRAME - 1)) begin
        errors++; $display("FAIL scan_frame_done[%0d]: got %b, expected %b", i, bus.frame_done, (i == FRAME - 1));
      end
      if (bus.anode_n[i / DWL] === 1'b0) lows[i / DWL]++;
    end
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (lows[k] != DWL - BL) begin errors++; $display("FAIL scan_lit_cycles[%0d]: got %0d, expected %0d", k, lows[k], DWL - BL); end
    end
  endtask

  task automatic test_handshake();
    bit ok;
    wait_fd(ok);
    repeat (8) @(negedge clk);
    bus.load_valid = 1'b1; bus.load_data = 16'hAAAA;
    @(negedge clk);
    bus.load_data = 16'h5555;
    checks++;
    if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_after_accept: got %b, expected 0", bus.load_ready); end
    @(negedge clk);
    bus.load_valid = 1'b0;
    checks++;
    if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_held: got %b, expected 0", bus.load_ready); end
    wait_fd(ok);
    checks++;
    if (!ok || bus.load_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_at_boundary: found=%b load_ready=%b, expected 1 0", ok, bus.load_ready); end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_after_boundary: got %b, expected 1", bus.load_ready); end
      end
      checks++;
      if (bus.nibble !== 4'hA) begin errors++; $display("FAIL hs_nibble[%0d]: got %h, expected %h", i, bus.nibble, 4'hA); end
    end
  endtask

  task automatic test_boundary();
    bit ok;
    wait_fd(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bnd_wait_frame: frame_done not seen, expected within %0d cycles", 3 * FRAME); end
    bus.load_valid = 1'b1; bus.load_data = 16'h0F00;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.load_valid = 1'b0;
        checks++;
        if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL bnd_accept: load_ready=%b, expected 0", bus.load_ready); end
      end
      checks++;
      if (bus.nibble !== 4'hA) begin errors++; $display("FAIL bnd_old_frame[%0d]: got %h, expected %h", i, bus.nibble, 4'hA); end
    end
    checks++;
    if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL bnd_frame_end: frame_done=%b, expected 1", bus.frame_done); end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (bus.nibble !== digit_of(16'h0F00, i / DWL)) begin
        errors++; $display("FAIL bnd_new_frame[%0d]: got %h, expected %h", i, bus.nibble, digit_of(16'h0F00, i / DWL));
      end
    end
  endtask

  task automatic test_config();
    bit ok;
    logic [ND-1:0] exp_a;
    bit lit;
    wait_fd(ok);
    repeat (5) @(negedge clk);
    bus.load_valid = 1'b1; bus.load_data = 16'h0070;
    @(negedge clk);
    bus.load_valid = 1'b0;
    wait_fd(ok);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      exp_a = '1;
      lit   = (i % DWL) >= BL;
`ifdef LEADING_ZERO_BLANK_EN
      if (i / DWL >= 2) lit = 0;
`endif
      if (lit) exp_a[i / DWL] = 1'b0;
      checks++;
      if (bus.anode_n !== exp_a || bus.nibble !== digit_of(16'h0070, i / DWL)) begin
        errors++;
        $display("FAIL cfg[%0d]: anode_n=%b nibble=%h, expected %b %h", i, bus.anode_n, bus.nibble, exp_a, digit_of(16'h0070, i / DWL));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    logic [ND-1:0] ea;
    for (int i = 0; i < 6 * FRAME; i++) begin
      @(negedge clk);
      ea = mdl_anode(m_t, m_active);
      checks++;
      if (bus.anode_n !== ea || bus.nibble !== digit_of(m_active, int'((m_t % FRAME) / DWL)) ||
          bus.frame_done !== ((m_t % FRAME) == FRAME - 1) || bus.load_ready !== !m_full) begin
        errors++;
        $display("FAIL rand[%0d]: anode_n=%b nibble=%h frame_done=%b load_ready=%b, expected %b %h %b %b",
                 i, bus.anode_n, bus.nibble, bus.frame_done, bus.load_ready,
                 ea, digit_of(m_active, int'((m_t % FRAME) / DWL)), ((m_t % FRAME) == FRAME - 1), !m_full);
      end
      r = 16'($urandom);
      bus.load_valid = ($urandom_range(0, 5) == 0);
      bus.load_data  = r >> (4 * $urandom_range(0, 3));
    end
    bus.load_valid = 1'b0;
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_scan();
    test_handshake();
    test_boundary();
    test_config();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion before time 500000");
    $fatal(1, "watchdog");
  end

endmodule
